// File: rtl/multi_channel_interval_timer.sv
`default_nettype none
// ============================================================================
// Module   : multi_channel_interval_timer
// Summary  : Avalon-MM bank of NUM_CH prescaled down-counting interval timers
//            with shared irq and per-channel irq_vec.
// Revision : 1.0
// ============================================================================
module multi_channel_interval_timer #(
  parameter int              NUM_CH       = 4,
  parameter int              CNT_W        = 32,
  parameter int              PRE_W        = 16,
  parameter longint unsigned RESET_PERIOD = 64'd99999,
  localparam int             ADDR_W       = ((NUM_CH > 1) ? $clog2(NUM_CH) : 0) + 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [15:0]       writedata,
  output logic [15:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec
);

  localparam int               WORDS     = CNT_W / 16;
  localparam logic [CNT_W-1:0] RST_COUNT = CNT_W'(RESET_PERIOD);

  logic              wr_en;
  logic [ADDR_W-1:0] addr_ch;
  logic [3:0]        addr_reg;
  logic [16*NUM_CH-1:0] rd_flat;
  logic [15:0]       readdata_q, readdata_d;

  assign wr_en    = chipselect & ~write_n;
  assign addr_ch  = address >> 4;
  assign addr_reg = address[3:0];

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0] counter_q, counter_d;
      logic [CNT_W-1:0] period_q, period_d;
      logic [CNT_W-1:0] snap_q, snap_d;
      logic [PRE_W-1:0] prescale_q, prescale_d;
      logic [PRE_W-1:0] pcnt_q, pcnt_d;
      logic [3:0]       ctrl_q, ctrl_d;
      logic             to_q, to_d;
      logic             run_q, run_d;
      logic             reload_q, reload_d;
      logic             sel, tick, timeout;
      logic [15:0]      rd_word;

      assign sel     = wr_en && (addr_ch == ADDR_W'(i));
      assign tick    = run_q && (pcnt_q == prescale_q);
      // A pending force reload pre-empts the tick, so it can never time out.
      assign timeout = tick && !reload_q && (counter_q == '0);

      always_comb begin
        counter_d  = counter_q;
        period_d   = period_q;
        snap_d     = snap_q;
        prescale_d = prescale_q;
        pcnt_d     = pcnt_q;
        ctrl_d     = ctrl_q;
        to_d       = to_q;
        run_d      = run_q;
        reload_d   = 1'b0;

        if (reload_q) begin
          counter_d = period_q;
          run_d     = 1'b0;
          pcnt_d    = '0;
        end else if (run_q) begin
          if (tick) begin
            pcnt_d = '0;
            if (counter_q == '0) begin
              counter_d = period_q;
              if (!ctrl_q[1]) run_d = 1'b0;
            end else begin
              counter_d = counter_q - CNT_W'(1);
            end
          end else begin
            pcnt_d = pcnt_q + PRE_W'(1);
          end
        end else begin
          pcnt_d = '0;
        end

        if (sel) begin
          case (addr_reg)
            4'd0: to_d = 1'b0;
            4'd1: begin
              ctrl_d = writedata[3:0];
              if (writedata[2])      run_d = 1'b1;
              else if (writedata[3]) run_d = 1'b0;
            end
            4'd2: prescale_d = writedata[PRE_W-1:0];
            default: ;
          endcase
          for (int k = 0; k < WORDS; k++) begin
            if (addr_reg == 4'(4 + k)) begin
              period_d[16*k +: 16] = writedata;
              reload_d             = 1'b1;
            end
            if (addr_reg == 4'(8 + k)) snap_d = counter_q;
          end
        end

        // Set after the status clear so a coincident event is never lost.
        if (timeout) to_d = 1'b1;
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          counter_q  <= RST_COUNT;
          period_q   <= RST_COUNT;
          snap_q     <= '0;
          prescale_q <= '0;
          pcnt_q     <= '0;
          ctrl_q     <= '0;
          to_q       <= 1'b0;
          run_q      <= 1'b0;
          reload_q   <= 1'b0;
        end else begin
          counter_q  <= counter_d;
          period_q   <= period_d;
          snap_q     <= snap_d;
          prescale_q <= prescale_d;
          pcnt_q     <= pcnt_d;
          ctrl_q     <= ctrl_d;
          to_q       <= to_d;
          run_q      <= run_d;
          reload_q   <= reload_d;
        end
      end

      always_comb begin
        rd_word = '0;
        case (addr_reg)
          4'd0:    rd_word = {14'd0, run_q, to_q};
          4'd1:    rd_word = {12'd0, ctrl_q};
          4'd2:    rd_word = 16'(prescale_q);
          default: ;
        endcase
        for (int k = 0; k < WORDS; k++) begin
          if (addr_reg == 4'(4 + k)) rd_word = period_q[16*k +: 16];
          if (addr_reg == 4'(8 + k)) rd_word = snap_q[16*k +: 16];
        end
      end

      assign rd_flat[16*i +: 16] = rd_word;
      assign irq_vec[i]          = to_q & ctrl_q[0];
    end
  endgenerate

  // Channels at or beyond NUM_CH match no slice and read back zero.
  always_comb begin
    readdata_d = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (addr_ch == ADDR_W'(ch)) readdata_d = rd_flat[16*ch +: 16];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata_q <= '0;
    else          readdata_q <= readdata_d;
  end

  assign readdata = readdata_q;
  assign irq      = |irq_vec;

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_interval_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_channel_interval_timer
// Summary  : Directed and randomized bus traffic against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_multi_channel_interval_timer;

  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = '0;
  logic [15:0] readdata;
  logic        irq;
  logic [3:0]  irq_vec;

  multi_channel_interval_timer #(
    .NUM_CH(4), .CNT_W(32), .PRE_W(16), .RESET_PERIOD(64'd99999)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq(irq), .irq_vec(irq_vec)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: per-channel timer state following the register rules.
  logic [31:0] m_period [NCH];
  logic [31:0] m_cnt    [NCH];
  logic [31:0] m_snap   [NCH];
  logic [15:0] m_pre    [NCH];
  logic [15:0] m_pcnt   [NCH];
  logic [3:0]  m_ctrl   [NCH];
  bit          m_to     [NCH];
  bit          m_run    [NCH];
  bit          m_reload [NCH];
  logic [15:0] m_rd;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_period[c] = 32'd99999; m_cnt[c] = 32'd99999; m_snap[c] = '0;
      m_pre[c] = '0; m_pcnt[c] = '0; m_ctrl[c] = '0;
      m_to[c] = 0; m_run[c] = 0; m_reload[c] = 0;
    end
    m_rd = '0;
  endtask

  function automatic logic [15:0] model_read(input logic [5:0] a);
    int c;
    c = int'(a[5:4]);
    case (a[3:0])
      4'd0: return {14'd0, m_run[c], m_to[c]};
      4'd1: return {12'd0, m_ctrl[c]};
      4'd2: return m_pre[c];
      4'd4: return m_period[c][15:0];
      4'd5: return m_period[c][31:16];
      4'd8: return m_snap[c][15:0];
      4'd9: return m_snap[c][31:16];
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [3:0] model_vec();
    logic [3:0] v;
    for (int c = 0; c < NCH; c++) v[c] = m_to[c] & m_ctrl[c][0];
    return v;
  endfunction

  task automatic model_step(input bit cs, input bit wn, input logic [5:0] a, input logic [15:0] wd);
    m_rd = model_read(a);
    for (int c = 0; c < NCH; c++) begin
      bit          wr;
      bit          ev;
      logic [31:0] cnt_before;
      wr = cs && !wn && (int'(a[5:4]) == c);
      ev = 0;
      cnt_before = m_cnt[c];
      if (m_reload[c]) begin
        m_cnt[c] = m_period[c]; m_run[c] = 0; m_pcnt[c] = '0;
      end else if (!m_run[c]) begin
        m_pcnt[c] = '0;
      end else if (m_pcnt[c] != m_pre[c]) begin
        m_pcnt[c] = m_pcnt[c] + 16'd1;
      end else begin
        m_pcnt[c] = '0;
        if (m_cnt[c] == 0) begin
          ev = 1;
          m_cnt[c] = m_period[c];
          m_run[c] = m_ctrl[c][1];
        end else begin
          m_cnt[c] = m_cnt[c] - 1;
        end
      end
      m_reload[c] = 0;
      if (wr) begin
        case (a[3:0])
          4'd0: m_to[c] = 0;
          4'd1: begin
            m_ctrl[c] = wd[3:0];
            if (wd[2])      m_run[c] = 1;
            else if (wd[3]) m_run[c] = 0;
          end
          4'd2: m_pre[c] = wd;
          4'd4: begin m_period[c][15:0]  = wd; m_reload[c] = 1; end
          4'd5: begin m_period[c][31:16] = wd; m_reload[c] = 1; end
          4'd8, 4'd9: m_snap[c] = cnt_before;
          default: ;
        endcase
      end
      if (ev) m_to[c] = 1;
    end
  endtask

  task automatic bus_cycle(input bit cs, input bit wn, input logic [5:0] a, input logic [15:0] wd);
    chipselect = cs; write_n = wn; address = a; writedata = wd;
    @(posedge clk);
    model_step(cs, wn, a, wd);
    @(negedge clk);
    check("rdata", {48'd0, readdata}, {48'd0, m_rd});
    check("irq_vec", {60'd0, irq_vec}, {60'd0, model_vec()});
    check("irq", {63'd0, irq}, {63'd0, |model_vec()});
  endtask

  task automatic wr(input int c, input int r, input logic [15:0] d);
    bus_cycle(1'b1, 1'b0, 6'((c << 4) | r), d);
  endtask

  task automatic rd(input int c, input int r);
    bus_cycle(1'b0, 1'b1, 6'((c << 4) | r), 16'h0);
  endtask

  task automatic idle();
    bus_cycle(1'b0, 1'b1, 6'($urandom), 16'($urandom));
  endtask

  task automatic wr_period(input int c, input logic [31:0] p);
    wr(c, 4, p[15:0]);
    wr(c, 5, p[31:16]);
  endtask

  // Counts idle cycles until irq_vec[c] rises, bounded by max_n.
  task automatic wait_vec(input int c, input int max_n, output int n);
    n = 0;
    while (!irq_vec[c] && n < max_n) begin
      idle();
      n++;
    end
  endtask

  initial begin
    int n;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_rdata", {48'd0, readdata}, 64'd0);
    check("rst_irq", {63'd0, irq}, 64'd0);
    check("rst_vec", {60'd0, irq_vec}, 64'd0);
    reset_n = 1'b1;

    rd(0, 4); check("t1_per_lo", {48'd0, readdata}, 64'h869F);
    rd(0, 5); check("t1_per_hi", {48'd0, readdata}, 64'h0001);
    rd(0, 0); check("t1_status", {48'd0, readdata}, 64'h0);
    check("t1_irq", {63'd0, irq}, 64'd0);

    wr_period(1, 32'd9); wr(1, 2, 16'd0); wr(1, 1, 16'h7);
    wait_vec(1, 40, n);
    check("t2_first_to", 64'(n), 64'd10);
    check("t2_vec", {60'd0, irq_vec}, 64'b0010);
    wr(1, 0, 16'h0);
    check("t2_cleared", {63'd0, irq_vec[1]}, 64'd0);
    wait_vec(1, 40, n);
    check("t2_gap", 64'(n), 64'd9);

    wr_period(2, 32'd3); wr(2, 2, 16'd4); wr(2, 1, 16'h5);
    wait_vec(2, 60, n);
    check("t3_first_to", 64'(n), 64'd20);
    rd(2, 0); rd(2, 0); check("t3_status", {48'd0, readdata}, 64'h1);
    wr(2, 8, 16'h0); rd(2, 8); check("t3_hold", {48'd0, readdata}, 64'd3);
    wr(2, 0, 16'h0); wr(2, 1, 16'h5);
    wait_vec(2, 60, n);
    check("t3_second_to", 64'(n), 64'd20);

    wr(0, 1, 16'h6);
    repeat (5) idle();
    wr(0, 4, 16'd100);
    idle();
    rd(0, 0); check("t4_status", {48'd0, readdata}, 64'h0);
    wr(0, 8, 16'h0);
    rd(0, 8); check("t4_cnt_lo", {48'd0, readdata}, 64'h0064);
    rd(0, 9); check("t4_cnt_hi", {48'd0, readdata}, 64'h0001);
    wr(0, 1, 16'hC); idle();
    rd(0, 0); check("t4_start_wins", {48'd0, readdata}, 64'h2);

    wr(0, 5, 16'd0); wr(0, 4, 16'd1000); wr(0, 2, 16'd0); wr(0, 1, 16'h4);
    repeat (488) idle();
    wr(0, 8, 16'h0);
    repeat (5) idle();
    rd(0, 8); check("t5_snap_lo", {48'd0, readdata}, 64'h0200);
    rd(0, 9); check("t5_snap_hi", {48'd0, readdata}, 64'h0000);
    repeat (3) idle();
    rd(0, 8); check("t5_snap_again", {48'd0, readdata}, 64'h0200);
    wr(0, 1, 16'h8);

    wr_period(3, 32'd4); wr(3, 2, 16'd0); wr(3, 0, 16'h0); wr(3, 1, 16'h7);
    repeat (9) idle();
    wr(3, 0, 16'h0);
    check("t6_keep_to", {63'd0, irq_vec[3]}, 64'd1);
    check("t6_irq", {63'd0, irq}, 64'd1);
    for (int c = 0; c < NCH; c++) begin
      wr(c, 1, 16'h8); wr_period(c, 32'(10 - c)); wr(c, 2, 16'd0); wr(c, 0, 16'h0);
    end
    for (int c = 0; c < NCH; c++) wr(c, 1, 16'h7);
    repeat (7) idle();
    check("t6_before", {60'd0, irq_vec}, 64'h0);
    idle();
    check("t6_all", {60'd0, irq_vec}, 64'hF);

    for (int i = 0; i < 3000; i++) begin
      int c, r, sel;
      logic [15:0] d;
      int regs [11] = '{0, 1, 2, 4, 5, 8, 9, 3, 6, 10, 15};
      c = $urandom_range(0, NCH - 1);
      r = regs[$urandom_range(0, 10)];
      sel = $urandom_range(0, 99);
      case (r)
        1:       d = 16'($urandom_range(0, 15));
        2:       d = 16'($urandom_range(0, 3));
        4:       d = 16'($urandom_range(0, 30));
        5:       d = ($urandom_range(0, 19) == 0) ? 16'd1 : 16'd0;
        default: d = 16'($urandom);
      endcase
      if (sel < 25) wr(c, r, d);
      else          idle();
    end

    @(negedge clk);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_rdata", {48'd0, readdata}, 64'd0);
    check("mid_rst_irq", {63'd0, irq}, 64'd0);
    check("mid_rst_vec", {60'd0, irq_vec}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(2, 4); check("mid_rst_per", {48'd0, readdata}, 64'h869F);
    rd(2, 0); check("mid_rst_status", {48'd0, readdata}, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
